// File: rtl/lpm_divide_stream_pkg.sv
// Shared constants and helpers for the lpm_divide streaming wrapper.
package lpm_divide_stream_pkg;

  localparam int TAG_V   = 1;
  localparam int TAG_DBZ = 0;
  localparam int TAG_W   = 2;

  localparam string REP_SIGNED   = "SIGNED";
  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REM_POS_TRUE = "TRUE";

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/lpm_divide.sv
// Pipelined integer divider with lpm_divide parameters, ports and rounding rules.
module lpm_divide
  import lpm_divide_stream_pkg::*;
#(
  parameter int    lpm_widthn            = 8,
  parameter int    lpm_widthd            = 8,
  parameter string lpm_nrepresentation   = "UNSIGNED",
  parameter string lpm_drepresentation   = "UNSIGNED",
  parameter string lpm_remainderpositive = "TRUE",
  parameter int    lpm_pipeline          = 0
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic [lpm_widthn-1:0] numer,
  input  logic [lpm_widthd-1:0] denom,
  output logic [lpm_widthn-1:0] quotient,
  output logic [lpm_widthd-1:0] remain
);

  localparam int XW      = ((lpm_widthn > lpm_widthd) ? lpm_widthn : lpm_widthd) + 2;
  localparam bit N_S     = (lpm_nrepresentation == REP_SIGNED);
  localparam bit D_S     = (lpm_drepresentation == REP_SIGNED);
  localparam bit REM_POS = (lpm_remainderpositive == REM_POS_TRUE);

  logic signed [XW-1:0] w_n, w_d, w_q, w_r;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_n = N_S ? {{(XW-lpm_widthn){numer[lpm_widthn-1]}}, numer} : {{(XW-lpm_widthn){1'b0}}, numer};
    w_d = D_S ? {{(XW-lpm_widthd){denom[lpm_widthd-1]}}, denom} : {{(XW-lpm_widthd){1'b0}}, denom};
    w_q = '0;
    w_r = '0;
    if (w_d != '0) begin
      w_q = w_n / w_d;
      w_r = w_n % w_d;
      // Truncating division leaves the remainder with the numerator's sign; fold it positive.
      if (REM_POS && w_r[XW-1]) begin
        if (!w_d[XW-1]) begin
          w_q = w_q - XW'(1);
          w_r = w_r + w_d;
        end else begin
          w_q = w_q + XW'(1);
          w_r = w_r - w_d;
        end
      end
    end
  end

  generate
    if (lpm_pipeline == 0) begin : g_comb
      assign quotient = w_q[lpm_widthn-1:0];
      assign remain   = w_r[lpm_widthd-1:0];
    end else begin : g_pipe
      logic [lpm_widthn-1:0] r_q [lpm_pipeline];
      logic [lpm_widthd-1:0] r_r [lpm_pipeline];

      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
          for (int i = 0; i < lpm_pipeline; i++) begin
            r_q[i] <= '0;
            r_r[i] <= '0;
          end
        end else if (clken) begin
          r_q[0] <= w_q[lpm_widthn-1:0];
          r_r[0] <= w_r[lpm_widthd-1:0];
          for (int i = 1; i < lpm_pipeline; i++) begin
            r_q[i] <= r_q[i-1];
            r_r[i] <= r_r[i-1];
          end
        end
      end

      assign quotient = r_q[lpm_pipeline-1];
      assign remain   = r_r[lpm_pipeline-1];
    end
  endgenerate

endmodule

// File: rtl/lpm_divide_rfifo.sv
// First-word-fall-through result FIFO; outputs keep the last head while empty.
module lpm_divide_rfifo
  import lpm_divide_stream_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  // NOTE: storage is left unreset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (i_wr)  r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      if (r_count != '0) r_last <= r_mem[r_rd_ptr];
      case ({i_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
  assign o_count = r_count;

  // Upstream credits make this unreachable; a hit means a result would be lost.
  a_no_overflow: assert property (@(posedge clock) disable iff (aclr)
                                  !(i_wr && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/lpm_divide_stream.sv
// Valid/ready wrapper around lpm_divide: operand register, tag line, credit issue, result FIFO.
module lpm_divide_stream
  import lpm_divide_stream_pkg::*;
#(
  parameter int    lpm_widthn            = 8,
  parameter int    lpm_widthd            = 8,
  parameter string lpm_nrepresentation   = "UNSIGNED",
  parameter string lpm_drepresentation   = "UNSIGNED",
  parameter string lpm_remainderpositive = "TRUE",
  parameter int    lpm_pipeline          = 2,
  parameter int    fifo_depth            = 4
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [lpm_widthn-1:0] in_numer,
  input  logic [lpm_widthd-1:0] in_denom,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [lpm_widthn-1:0] out_quotient,
  output logic [lpm_widthd-1:0] out_remain,
  output logic                  out_dbz
);

  localparam int P     = lpm_pipeline;
  localparam int RW    = lpm_widthn + lpm_widthd + 1;
  localparam int CNT_W = clog2(fifo_depth + 1);

  logic                  r_en;
  logic [lpm_widthn-1:0] r_numer;
  logic [lpm_widthd-1:0] r_denom;
  logic [TAG_W-1:0]      r_tag [P+1];  // [0] travels with the operand register
  logic                  w_accept, w_dbz_in, w_wr;
  logic [lpm_widthn-1:0] w_quot;
  logic [lpm_widthd-1:0] w_rem;
  logic [RW-1:0]         w_wr_data, w_rd_data;
  logic [CNT_W-1:0]      w_count;
  int                    w_inflight;

  assign w_dbz_in = (in_denom == '0);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_en    <= 1'b0;
      r_numer <= '0;
      r_denom <= '0;
      for (int i = 0; i <= P; i++) r_tag[i] <= '0;
    end else begin
      r_en              <= 1'b1;
      r_tag[0][TAG_V]   <= w_accept;
      r_tag[0][TAG_DBZ] <= w_accept && w_dbz_in;
      for (int i = 1; i <= P; i++) r_tag[i] <= r_tag[i-1];
      if (w_accept) begin
        r_numer <= in_numer;
        r_denom <= w_dbz_in ? lpm_widthd'(1) : in_denom;
      end
    end
  end

  // Every valid tag is a result already promised a FIFO slot.
  always_comb begin
    w_inflight = 0;
    for (int i = 0; i <= P; i++) w_inflight += int'(r_tag[i][TAG_V]);
  end

  assign in_ready = r_en && ((int'(w_count) + w_inflight) < fifo_depth);

  lpm_divide #(
    .lpm_widthn           (lpm_widthn),
    .lpm_widthd           (lpm_widthd),
    .lpm_nrepresentation  (lpm_nrepresentation),
    .lpm_drepresentation  (lpm_drepresentation),
    .lpm_remainderpositive(lpm_remainderpositive),
    .lpm_pipeline         (P)
  ) u_div (
    .clock   (clock),
    .aclr    (aclr),
    .clken   (1'b1),
    .numer   (r_numer),
    .denom   (r_denom),
    .quotient(w_quot),
    .remain  (w_rem)
  );

  assign w_wr      = r_tag[P][TAG_V];
  assign w_wr_data = r_tag[P][TAG_DBZ] ? {{lpm_widthn{1'b1}}, {lpm_widthd{1'b0}}, 1'b1}
                                       : {w_quot, w_rem, 1'b0};

  lpm_divide_rfifo #(
    .WIDTH(RW),
    .DEPTH(fifo_depth),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clock  (clock),
    .aclr   (aclr),
    .i_wr   (w_wr),
    .i_data (w_wr_data),
    .i_pop  (out_ready),
    .o_valid(out_valid),
    .o_data (w_rd_data),
    .o_count(w_count)
  );

  assign out_quotient = w_rd_data[RW-1 -: lpm_widthn];
  assign out_remain   = w_rd_data[lpm_widthd:1];
  assign out_dbz      = w_rd_data[0];

endmodule

// File: tb/tb_lpm_divide_stream.sv
// Bench: unsigned and signed wrappers driven in lockstep, checked against a queue-based model.
module tb_lpm_divide_stream;

  localparam int P     = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] qu, ru, qs, rs;
    logic       dbz;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       aclr;
  logic       in_valid, out_ready;
  logic [7:0] in_numer, in_denom;

  logic       in_ready_u, out_valid_u, dbz_u, in_ready_s, out_valid_s, dbz_s;
  logic [7:0] q_u, r_u, q_s, r_s;

  int   n_vec = 0, n_fail = 0;
  int   acc_dut = 0, pop_dut = 0, edge_n = 0;
  bit   m_en = 1'b0;
  logic m_acc = 1'b0;
  exp_t pipe_q[$], res_q[$];
  exp_t last_e = '0;
  logic [7:0] vn [16], vd [16];

  always #5 clk = ~clk;

  lpm_divide_stream #(
    .lpm_widthn(8), .lpm_widthd(8),
    .lpm_nrepresentation("UNSIGNED"), .lpm_drepresentation("UNSIGNED"),
    .lpm_remainderpositive("TRUE"), .lpm_pipeline(P), .fifo_depth(DEPTH)
  ) u_dut_u (
    .clock(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_numer(in_numer), .in_denom(in_denom), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_quotient(q_u), .out_remain(r_u), .out_dbz(dbz_u)
  );

  lpm_divide_stream #(
    .lpm_widthn(8), .lpm_widthd(8),
    .lpm_nrepresentation("SIGNED"), .lpm_drepresentation("SIGNED"),
    .lpm_remainderpositive("TRUE"), .lpm_pipeline(P), .fifo_depth(DEPTH)
  ) u_dut_s (
    .clock(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_numer(in_numer), .in_denom(in_denom), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_quotient(q_s), .out_remain(r_s), .out_dbz(dbz_s)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Unsigned: plain division. Signed with positive remainder: Euclidean division.
  function automatic exp_t model_div(input logic [7:0] n, input logic [7:0] d);
    exp_t e;
    int   ns, ds, ad, rr;
    e = '0;
    e.dbz = (d == 8'd0);
    if (e.dbz) begin
      e.qu = 8'hFF; e.qs = 8'hFF;
      return e;
    end
    e.qu = 8'(int'(n) / int'(d));
    e.ru = 8'(int'(n) % int'(d));
    ns = int'($signed(n));
    ds = int'($signed(d));
    ad = (ds < 0) ? -ds : ds;
    rr = ((ns % ad) + ad) % ad;
    e.qs = 8'((ns - rr) / ds);
    e.rs = 8'(rr);
    return e;
  endfunction

  always @(posedge clk or posedge aclr) begin
    if (aclr) m_en <= 1'b0;
    else      m_en <= 1'b1;
  end

  // Compare every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic exp_valid, exp_ready, pop;
    exp_t e;
    if (aclr) begin
      pipe_q.delete();
      res_q.delete();
      last_e = '0;
    end
    exp_valid = (res_q.size() != 0);
    if (exp_valid) last_e = res_q[0];
    exp_ready = m_en && ((pipe_q.size() + res_q.size()) < DEPTH);
    check("u_in_ready",  32'(in_ready_u),  32'(exp_ready));
    check("u_out_valid", 32'(out_valid_u), 32'(exp_valid));
    check("u_quotient",  32'(q_u),         32'(last_e.qu));
    check("u_remain",    32'(r_u),         32'(last_e.ru));
    check("u_dbz",       32'(dbz_u),       32'(last_e.dbz));
    check("s_in_ready",  32'(in_ready_s),  32'(exp_ready));
    check("s_out_valid", 32'(out_valid_s), 32'(exp_valid));
    check("s_quotient",  32'(q_s),         32'(last_e.qs));
    check("s_remain",    32'(r_s),         32'(last_e.rs));
    check("s_dbz",       32'(dbz_s),       32'(last_e.dbz));
    m_acc = 1'b0;
    if (!aclr) begin
      if (in_valid && in_ready_u)    acc_dut++;
      if (out_valid_u && out_ready)  pop_dut++;
      m_acc = in_valid && exp_ready;
      pop   = exp_valid && out_ready;
      edge_n++;
      if (pop) void'(res_q.pop_front());
      while (pipe_q.size() != 0 && pipe_q[0].due == edge_n) res_q.push_back(pipe_q.pop_front());
      if (m_acc) begin
        e = model_div(in_numer, in_denom);
        e.due = edge_n + P + 1;
        pipe_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] n, input logic [7:0] d);
    int k;
    in_valid = 1'b1; in_numer = n; in_denom = d;
    k = 0;
    do begin tick(); k++; end while (!m_acc && k < 50);
    check("send_accepted", 32'(m_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // Offer table entries back to back until cnt are accepted or the budget runs out.
  task automatic stream(input int first, input int cnt, input int budget);
    int idx, k;
    idx = 0; k = 0;
    in_valid = 1'b1; in_numer = vn[first % 16]; in_denom = vd[first % 16];
    while (idx < cnt && k < budget) begin
      tick(); k++;
      if (m_acc) begin
        idx++;
        in_numer = vn[(first + idx) % 16]; in_denom = vd[(first + idx) % 16];
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((pipe_q.size() + res_q.size()) != 0 && k < 100) begin tick(); k++; end
    check("drain_done", 32'(pipe_q.size() + res_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0;
    vn = '{8'd100, 8'hF9, 8'd55, 8'd9,  8'h80, 8'd200, 8'h7F, 8'd0,
           8'd255, 8'h9C, 8'd1,  8'd13, 8'hF0, 8'd77,  8'h81, 8'd250};
    vd = '{8'd7,   8'd2,  8'd0,  8'd3,  8'hFF, 8'd13,  8'hFE, 8'd5,
           8'd1,   8'd7,  8'd0,  8'd200, 8'hF1, 8'd77, 8'd2,  8'd3};
    aclr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_numer = '0; in_denom = '0;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid_u), 32'd0);
    check("rst_in_ready",  32'(in_ready_u),  32'd0);
    check("rst_quotient",  32'(q_u),         32'd0);
    aclr = 1'b0;
    tick();
    check("rst_ready_rise", 32'(in_ready_u), 32'd1);

    // T1: latency and basic unsigned result
    send(8'd100, 8'd7);
    tick(); tick();
    check("t1_not_yet", 32'(out_valid_u), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid_u), 32'd1);
    check("t1_q",     32'(q_u),         32'd14);
    check("t1_r",     32'(r_u),         32'd2);
    check("t1_dbz",   32'(dbz_u),       32'd0);
    drain();

    // T2: -7 / 2 with positive remainder
    send(8'hF9, 8'h02);
    repeat (3) tick();
    check("t2_s_q", 32'(q_s), 32'hFC);
    check("t2_s_r", 32'(r_s), 32'h01);
    check("t2_u_q", 32'(q_u), 32'h7C);
    drain();

    // T3: divide by zero followed by a normal op
    send(8'd55, 8'd0);
    send(8'd9, 8'd3);
    repeat (2) tick();
    check("t3_dbz_q",   32'(q_s),   32'hFF);
    check("t3_dbz_r",   32'(r_s),   32'h00);
    check("t3_dbz_flg", 32'(dbz_u), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t3_next_q",   32'(q_u),   32'd3);
    check("t3_next_r",   32'(r_u),   32'd0);
    check("t3_next_dbz", 32'(dbz_u), 32'd0);
    tick();
    out_ready = 1'b0;

    // T4: backpressure stops issue after four credits
    a0 = acc_dut;
    stream(0, 8, 10);
    check("t4_accepted", 32'(acc_dut - a0), 32'd4);
    check("t4_stalled",  32'(in_ready_u),   32'd0);
    out_ready = 1'b1;
    stream(4, 4, 60);
    drain();
    check("t4_total", 32'(acc_dut - a0), 32'd8);

    // T5: sixteen back-to-back ops with the consumer always ready
    p0 = pop_dut;
    out_ready = 1'b1;
    stream(0, 16, 200);
    drain();
    check("t5_results", 32'(pop_dut - p0), 32'd16);

    // T6: reset with results both in flight and buffered
    stream(8, 4, 20);
    tick();
    aclr = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid_u), 32'd0);
    check("t6_rst_q",     32'(q_u),         32'd0);
    check("t6_rst_ready", 32'(in_ready_u),  32'd0);
    tick();
    aclr = 1'b0;
    repeat (3) begin
      tick();
      check("t6_no_stale", 32'(out_valid_u), 32'd0);
    end
    send(8'd200, 8'd13);
    repeat (3) tick();
    check("t6_new_q", 32'(q_u), 32'd15);
    check("t6_new_r", 32'(r_u), 32'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
